mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, range 1..15; max consecutive DM grants while IF waits.
REQ-004 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-005 SHALL have port start_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req_i in 1, if_addr_i in ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports if_ack_o out 1, if_rdata_o out DATA_W: fetch completion pulse and read data.
REQ-008 SHALL have ports dm_req_i in 1, dm_we_i in 1, dm_addr_i in ADDR_W, dm_wdata_i in DATA_W: data request, write enable, address, write data.
REQ-009 SHALL have ports dm_ack_o out 1, dm_rdata_o out DATA_W: data completion pulse and read data.
REQ-010 SHALL have ports mem_req_o, mem_we_o out 1, mem_addr_o out ADDR_W, mem_wdata_o out DATA_W: shared single-port memory request.
REQ-011 SHALL have ports mem_ack_i in 1, mem_rdata_i in DATA_W: memory completion and read data, valid together.
REQ-012 SHALL have port stall_o  out  1  pipeline freeze request.

Function
REQ-013 FSM SHALL have states IDLE, IF_BUSY, DM_BUSY, RESP.
REQ-014 In IDLE with any request, SHALL grant one requester, capture its addr/we/wdata into registers, and enter the matching BUSY state at the next edge.
REQ-015 Grant priority SHALL be DM over IF, except IF SHALL win when starve_cnt == STARVE_MAX.
REQ-016 starve_cnt (4 bit) SHALL increment on each DM grant while if_req_i=1.
REQ-017 starve_cnt SHALL clear on IF grant, SHALL saturate at STARVE_MAX, and SHALL hold when if_req_i=0.
REQ-018 In BUSY, mem_req_o SHALL be 1, and mem_addr_o/mem_we_o/mem_wdata_o SHALL be driven from the captured registers, stable until ack.
REQ-019 mem_we_o SHALL be 0 for IF grants.
REQ-020 In BUSY with mem_ack_i=1, SHALL register mem_rdata_i into the granted requester's rdata output and enter RESP.
REQ-021 In RESP, SHALL assert exactly one of if_ack_o/dm_ack_o for one cycle, hold mem_req_o=0, and return to IDLE.
REQ-022 A request seen in RESP SHALL NOT be granted; requesters treat the ack edge as completion.
REQ-023 rdata outputs SHALL hold their value until the next completion to the same requester.
REQ-024 rdata SHALL NOT update on a DM write.
REQ-025 Latency: req in IDLE cycle 0, mem_req_o cycles 1..k with mem_ack_i in cycle k, ack_o in cycle k+1, IDLE in cycle k+2; minimum 3 cycles per access.
REQ-026 mem_ack_i in IDLE or RESP SHALL be ignored with no state change.
REQ-027 stall_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-028 Requester inputs SHALL be sampled only at grant; changes while BUSY SHALL have no effect.
REQ-029 Simultaneous if_req_i and dm_req_i SHALL follow REQ-015; the loser remains pending and is granted in a later IDLE.

Reset
REQ-030 start_i=0 SHALL asynchronously force IDLE and starve_cnt=0.
REQ-031 start_i=0 SHALL asynchronously force all outputs and captured registers to 0.
REQ-032 Reset during BUSY/RESP SHALL abandon the transaction with no ack.
REQ-033 A late mem_ack_i after reset release SHALL be ignored per REQ-026.
REQ-034 Reset release SHALL be effective from the first rising clk_i with start_i=1.

Structure
REQ-035 Shared package cpu_mem_pkg SHALL hold the state enum, grant enum {GNT_NONE, GNT_IF, GNT_DM}, and default ADDR_W/DATA_W.
REQ-036 Priority/starvation selection SHALL be one sub-module mem_arb_prio (inputs: reqs, starve_cnt; output: grant).
REQ-037 Everything else SHALL be flat in mem_arbiter; target 150-300 lines.

Verification
REQ-038 Single IF read: if_req_i=1, if_addr_i=0x40, memory acks 2 cycles after mem_req_o with 0x8C010004 -> if_ack_o pulse with if_rdata_o=0x8C010004, mem_we_o=0 throughout, stall_o high until ack cycle.
REQ-039 Simultaneous: IF@0x44, DM write 0x100<=0xDEADBEEF -> DM served first (mem_we_o=1, mem_wdata_o=0xDEADBEEF), then IF; dm_rdata_o unchanged.
REQ-040 Starvation, STARVE_MAX=4: dm_req_i and if_req_i held high continuously -> grant order DM,DM,DM,DM,IF, repeating.
REQ-041 Reset mid-op: start_i low in DM_BUSY, mem_ack_i=1 one cycle after release -> no dm_ack_o, all outputs 0, FSM IDLE.
REQ-042 Spurious: mem_ack_i=1 in IDLE with no requests -> no ack outputs, rdata unchanged, mem_req_o=0.
REQ-043 Input hold: dm_addr_i changed 0x100->0x200 during DM_BUSY -> mem_addr_o stays 0x100 until ack.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and default widths for the CPU memory arbiter
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Arbiter sequencing: one access in flight, one response cycle, then idle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } arbState_t;

  // Which requester the priority logic would serve this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-over-fetch priority with fetch starvation override
module mem_arb_prio
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic [1:0] reqs,       // bit 0: fetch, bit 1: data
  input  logic [3:0] starveCnt,
  output grant_t     grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic ifReq;
  logic dmReq;
  logic ifStarved;

  assign ifReq     = reqs[0];
  assign dmReq     = reqs[1];
  assign ifStarved = ifReq && (starveCnt == STARVE_LIM);

  // Data wins by default; a fetch that has waited out STARVE_MAX data grants goes first.
  always_comb begin
    grant = GNT_NONE;
    if (dmReq && !ifStarved) begin
      grant = GNT_DM;
    end else if (ifReq) begin
      grant = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (fetch/data) arbiter onto one single-port memory
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arbState_t         state;
  grant_t            grant;
  logic [3:0]        starveCnt;
  logic              memReq;
  logic              capWe;
  logic [ADDR_W-1:0] capAddr;
  logic [DATA_W-1:0] capWdata;
  logic              ifAck;
  logic              dmAck;
  logic [DATA_W-1:0] ifRdata;
  logic [DATA_W-1:0] dmRdata;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) uPrio (
    .reqs      ({dm_req_i, if_req_i}),
    .starveCnt (starveCnt),
    .grant     (grant)
  );

  // Grant, hold the captured request on the memory port until ack, then pulse the requester's ack.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state     <= IDLE;
      starveCnt <= '0;
      memReq    <= 1'b0;
      capWe     <= 1'b0;
      capAddr   <= '0;
      capWdata  <= '0;
      ifAck     <= 1'b0;
      dmAck     <= 1'b0;
      ifRdata   <= '0;
      dmRdata   <= '0;
    end else begin
      ifAck <= 1'b0;
      dmAck <= 1'b0;
      case (state)
        IDLE: begin
          case (grant)
            GNT_DM: begin
              state    <= DM_BUSY;
              memReq   <= 1'b1;
              capWe    <= dm_we_i;
              capAddr  <= dm_addr_i;
              capWdata <= dm_wdata_i;
              if (if_req_i && (starveCnt < STARVE_LIM)) begin
                starveCnt <= starveCnt + 4'd1;
              end
            end
            GNT_IF: begin
              state     <= IF_BUSY;
              memReq    <= 1'b1;
              capWe     <= 1'b0;
              capAddr   <= if_addr_i;
              capWdata  <= '0;
              starveCnt <= '0;
            end
            default: ;
          endcase
        end
        IF_BUSY: begin
          if (mem_ack_i) begin
            state   <= RESP;
            memReq  <= 1'b0;
            ifAck   <= 1'b1;
            ifRdata <= mem_rdata_i;
          end
        end
        DM_BUSY: begin
          if (mem_ack_i) begin
            state  <= RESP;
            memReq <= 1'b0;
            dmAck  <= 1'b1;
            if (!capWe) begin
              dmRdata <= mem_rdata_i;
            end
          end
        end
        RESP: begin
          // Requests seen here are deliberately not granted; the requester sees its ack this cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = memReq;
  assign mem_we_o    = capWe;
  assign mem_addr_o  = capAddr;
  assign mem_wdata_o = capWdata;
  assign if_ack_o    = ifAck;
  assign dm_ack_o    = dmAck;
  assign if_rdata_o  = ifRdata;
  assign dm_rdata_o  = dmRdata;

  // Freeze the pipeline while any request is outstanding, released in its ack cycle.
  assign stall_o = (if_req_i & ~ifAck) | (dm_req_i & ~dmAck);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int SM     = 4;
  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_RESP = 2;

  logic        clk = 1'b0;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory contents and transaction-level model of the arbiter.
  logic [31:0] memArr [logic [31:0]];
  int          mPhase, mWho, mStarve, memWait, forceLat;
  logic        mWe;
  logic [31:0] mAddr, mWdata, expIfRdata, expDmRdata;

  // Requester agents.
  bit          ifPend, dmPend, autoIf, autoDm, holdIf, holdDm, spurious, scramble;
  logic [31:0] ifAddr, dmAddr, dmWdata;
  logic        dmWe;
  int          ackLog [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic bit ifAckExp();
    return (mPhase == P_RESP) && (mWho == 1);
  endfunction

  function automatic bit dmAckExp();
    return (mPhase == P_RESP) && (mWho == 2);
  endfunction

  // Apply the arbitration rules to the inputs present at this rising edge.
  task automatic modelEdge();
    bit dmWins;
    if (mPhase == P_IDLE) begin
      if (dm_req_i || if_req_i) begin
        dmWins = dm_req_i && !(if_req_i && (mStarve == SM));
        if (dmWins) begin
          mWho = 2; mWe = dm_we_i; mAddr = dm_addr_i; mWdata = dm_wdata_i;
          if (if_req_i && (mStarve < SM)) mStarve++;
        end else begin
          mWho = 1; mWe = 1'b0; mAddr = if_addr_i; mWdata = 32'h0;
          mStarve = 0;
        end
        mPhase  = P_BUSY;
        memWait = (forceLat >= 0) ? forceLat : int'($urandom_range(0, 3));
      end
    end else if (mPhase == P_BUSY) begin
      if (mem_ack_i) begin
        mPhase = P_RESP;
        if (mWho == 1) expIfRdata = memRead(mAddr);
        else if (!mWe) expDmRdata = memRead(mAddr);
        else memArr[mAddr] = mWdata;
      end
    end else begin
      mPhase = P_IDLE;
    end
  endtask

  task automatic checkOutputs();
    check("mem_req", 64'(mem_req_o), 64'(mPhase == P_BUSY));
    if (mPhase == P_BUSY) begin
      check("mem_addr", 64'(mem_addr_o), 64'(mAddr));
      check("mem_we", 64'(mem_we_o), 64'(mWe));
      if (mWe) check("mem_wdata", 64'(mem_wdata_o), 64'(mWdata));
    end
    check("if_ack", 64'(if_ack_o), 64'(ifAckExp()));
    check("dm_ack", 64'(dm_ack_o), 64'(dmAckExp()));
    check("if_rdata", 64'(if_rdata_o), 64'(expIfRdata));
    check("dm_rdata", 64'(dm_rdata_o), 64'(expDmRdata));
    check("stall", 64'(stall_o), 64'((if_req_i & ~ifAckExp()) | (dm_req_i & ~dmAckExp())));
  endtask

  task automatic driveNext();
    if (ifAckExp() && !holdIf) ifPend = 1'b0;
    if (dmAckExp() && !holdDm) dmPend = 1'b0;
    if (scramble && (mPhase == P_BUSY)) begin
      if (mWho == 1) ifAddr = $urandom;
      else begin dmAddr = $urandom; dmWe = 1'($urandom); dmWdata = $urandom; end
    end
    if (autoIf && !ifPend && ($urandom_range(0, 2) == 0)) begin
      ifPend = 1'b1; ifAddr = 32'h100 + 32'(4 * $urandom_range(0, 15));
    end
    if (autoDm && !dmPend && ($urandom_range(0, 2) == 0)) begin
      dmPend = 1'b1; dmWe = 1'($urandom); dmWdata = $urandom;
      dmAddr = 32'h100 + 32'(4 * $urandom_range(0, 15));
    end
    if_req_i = ifPend; if_addr_i = ifAddr;
    dm_req_i = dmPend; dm_we_i = dmWe; dm_addr_i = dmAddr; dm_wdata_i = dmWdata;
    if (mPhase == P_BUSY) begin
      if (memWait == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mWe ? $urandom : memRead(mAddr);
      end else begin
        memWait--;
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
      end
    end else begin
      mem_ack_i   = spurious ? 1'($urandom) : 1'b0;
      mem_rdata_i = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutputs();
    if (if_ack_o) ackLog.push_back(1);
    if (dm_ack_o) ackLog.push_back(2);
    driveNext();
  endtask

  task automatic runUntilIdle(input int maxCyc);
    int n = 0;
    while ((ifPend || dmPend || (mPhase != P_IDLE)) && (n < maxCyc)) begin
      tick();
      n++;
    end
    check("idle_budget", 64'(n < maxCyc), 64'(1));
  endtask

  task automatic waitAcks(input int count, input int maxCyc);
    int n = 0;
    while ((ackLog.size() < count) && (n < maxCyc)) begin
      tick();
      n++;
    end
    check("ack_budget", 64'(ackLog.size() >= count), 64'(1));
  endtask

  task automatic issueIf(input logic [31:0] a);
    ifPend = 1'b1; ifAddr = a;
    if_req_i = 1'b1; if_addr_i = a;
  endtask

  task automatic issueDm(input logic we, input logic [31:0] a, input logic [31:0] d);
    dmPend = 1'b1; dmWe = we; dmAddr = a; dmWdata = d;
    dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = a; dm_wdata_i = d;
  endtask

  // Assert reset mid-cycle, check the cleared outputs, release on a falling edge.
  task automatic applyReset(input bit lateAck);
    #3;
    start_i = 1'b0;
    ifPend = 1'b0; dmPend = 1'b0;
    if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
    mPhase = P_IDLE; mStarve = 0; expIfRdata = 32'h0; expDmRdata = 32'h0;
    #1;
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_mem_we", 64'(mem_we_o), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
    check("rst_if_ack", 64'(if_ack_o), 64'(0));
    check("rst_dm_ack", 64'(dm_ack_o), 64'(0));
    check("rst_if_rdata", 64'(if_rdata_o), 64'(0));
    check("rst_dm_rdata", 64'(dm_rdata_o), 64'(0));
    check("rst_stall", 64'(stall_o), 64'(0));
    @(negedge clk);
    @(negedge clk);
    start_i     = 1'b1;
    mem_ack_i   = lateAck;
    mem_rdata_i = 32'hBAD0_BAD0;
  endtask

  initial begin
    start_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    ifAddr = 32'h0; dmAddr = 32'h0; dmWdata = 32'h0; dmWe = 1'b0;
    mWho = 0; mWe = 1'b0; mAddr = 32'h0; mWdata = 32'h0; memWait = 0; forceLat = -1;
    {autoIf, autoDm, holdIf, holdDm, spurious, scramble} = '0;

    applyReset(1'b0);
    repeat (2) tick();

    // Single fetch, memory acks two cycles after the request appears.
    memArr[32'h40] = 32'h8C01_0004;
    forceLat = 2;
    ackLog.delete();
    issueIf(32'h40);
    repeat (3) tick();
    check("if_no_early_ack", 64'(ackLog.size()), 64'(0));
    tick();
    check("if_ack_cycle", 64'(if_ack_o), 64'(1));
    check("if_rdata_val", 64'(if_rdata_o), 64'(32'h8C01_0004));
    runUntilIdle(20);

    // Simultaneous fetch and data write: data first, then fetch.
    forceLat = -1;
    ackLog.delete();
    issueIf(32'h44);
    issueDm(1'b1, 32'h100, 32'hDEAD_BEEF);
    runUntilIdle(40);
    check("sim_ack_count", 64'(ackLog.size()), 64'(2));
    check("sim_first_dm", 64'(ackLog.size() > 0 ? ackLog[0] : 0), 64'(2));
    check("sim_then_if", 64'(ackLog.size() > 1 ? ackLog[1] : 0), 64'(1));
    check("sim_dm_rdata_kept", 64'(dm_rdata_o), 64'(0));

    // Both requesters held high: four data grants, then one fetch, repeating.
    applyReset(1'b0);
    ackLog.delete();
    holdIf = 1'b1; holdDm = 1'b1;
    issueIf(32'h80);
    issueDm(1'b0, 32'h90, 32'h0);
    waitAcks(10, 200);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("starve_order_%0d", i), 64'(i < ackLog.size() ? ackLog[i] : 0),
            64'(((i % 5) == 4) ? 1 : 2));
    end
    holdIf = 1'b0; holdDm = 1'b0;
    runUntilIdle(60);

    // Data address changes while busy must not reach the memory port.
    forceLat = 3;
    issueDm(1'b0, 32'h100, 32'h0);
    tick();
    dmAddr = 32'h200; dm_addr_i = 32'h200;
    tick();
    check("hold_addr", 64'(mem_addr_o), 64'(32'h100));
    runUntilIdle(20);
    check("hold_read_data", 64'(dm_rdata_o), 64'(32'hDEAD_BEEF));

    // Reset during a data access, then a late memory ack.
    forceLat = 6;
    ackLog.delete();
    issueDm(1'b1, 32'h300, 32'h1234);
    repeat (2) tick();
    applyReset(1'b1);
    forceLat = -1;
    repeat (4) tick();
    check("rst_no_ack", 64'(ackLog.size()), 64'(0));
    check("rst_idle_req", 64'(mem_req_o), 64'(0));

    // Spurious memory ack while idle.
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    repeat (3) tick();
    check("spur_mem_req", 64'(mem_req_o), 64'(0));
    check("spur_no_ack", 64'(ackLog.size()), 64'(0));
    check("spur_dm_rdata", 64'(dm_rdata_o), 64'(0));

    // Randomized traffic with spurious acks and scrambled inputs while busy.
    autoIf = 1'b1; autoDm = 1'b1; spurious = 1'b1; scramble = 1'b1;
    repeat (3000) tick();
    autoIf = 1'b0; autoDm = 1'b0; spurious = 1'b0; scramble = 1'b0;
    runUntilIdle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
